// File: rtl/peripheral_ahb4_pkg.sv
// Shared AHB4-Lite definitions for the peripheral interconnect: HTRANS codes
// and the slave-port arbiter state encoding.
package peripheral_ahb4_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    // IDLE: nobody requesting; OWNED: owner may lose at the next boundary;
    // HOLD: owner is mid-burst or locked and cannot lose.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_OWNED = 2'b01,
        ST_HOLD  = 2'b10
    } arb_state_e;

endpackage

// File: rtl/peripheral_arbiter_pick_ahb4.sv
// Combinational candidate pick: highest priority among requesters, ties broken
// round-robin starting at last_id+1. Bus-agnostic so other flavours can reuse it.
module peripheral_arbiter_pick_ahb4 #(
    parameter int MASTERS       = 3,
    parameter int PRIORITY_BITS = 3
) (
    input  logic [MASTERS-1:0]               req_i,
    input  logic [MASTERS*PRIORITY_BITS-1:0] priority_i,
    input  logic [$clog2(MASTERS)-1:0]       last_id_i,
    output logic [MASTERS-1:0]               pick_o,
    output logic [$clog2(MASTERS)-1:0]       pick_id_o
);

    localparam int IDW = $clog2(MASTERS);

    logic [PRIORITY_BITS-1:0] pri [MASTERS];
    logic [PRIORITY_BITS-1:0] best_pri;
    logic [IDW-1:0]           idx;
    logic                     found;

    always_comb begin
        for (int i = 0; i < MASTERS; i++) begin
            pri[i] = priority_i[i*PRIORITY_BITS +: PRIORITY_BITS];
        end
    end

    // Scan in round-robin order; strict '>' keeps the earliest tied candidate.
    always_comb begin
        pick_id_o = '0;
        best_pri  = '0;
        found     = 1'b0;
        idx       = '0;
        for (int k = 1; k <= MASTERS; k++) begin
            idx = IDW'((int'(last_id_i) + k) % MASTERS);
            if (req_i[idx] && (!found || (pri[idx] > best_pri))) begin
                found     = 1'b1;
                best_pri  = pri[idx];
                pick_id_o = idx;
            end
        end
        pick_o            = '0;
        pick_o[pick_id_o] = found;
    end

endmodule

// File: rtl/peripheral_arbiter_ahb4.sv
// Per-slave-port master arbiter: registered address-phase grant with burst/lock
// hold, plus data-phase owner tracking for response routing.
module peripheral_arbiter_ahb4
    import peripheral_ahb4_pkg::*;
#(
    parameter int MASTERS       = 3,
    parameter int PRIORITY_BITS = 3
) (
    input  logic                               HCLK,
    input  logic                               HRESETn,
    input  logic [MASTERS*PRIORITY_BITS-1:0]   mst_priority,
    input  logic [MASTERS-1:0]                 mst_req,
    input  logic [2*MASTERS-1:0]               mst_HTRANS,
    input  logic [MASTERS-1:0]                 mst_HMASTLOCK,
    input  logic                               slv_HREADY,
    output logic [MASTERS-1:0]                 grant,
    output logic [$clog2(MASTERS)-1:0]         grant_id,
    output logic                               grant_valid,
    output logic [$clog2(MASTERS)-1:0]         data_id,
    output logic                               data_valid,
    output arb_state_e                         dbg_state_o
);

    localparam int IDW = $clog2(MASTERS);

    arb_state_e         state_q, state_d;
    logic [MASTERS-1:0] grant_q, grant_d;
    logic [IDW-1:0]     grant_id_q, grant_id_d;
    logic [IDW-1:0]     last_id_q, last_id_d;
    logic [IDW-1:0]     data_id_q, data_id_d;
    logic               data_valid_q, data_valid_d;

    logic [1:0]         trans [MASTERS];
    logic [1:0]         owner_trans;
    logic               owner_hold;
    logic [MASTERS-1:0] pick;
    logic [IDW-1:0]     pick_id;

    peripheral_arbiter_pick_ahb4 #(
        .MASTERS       (MASTERS),
        .PRIORITY_BITS (PRIORITY_BITS)
    ) u_pick (
        .req_i      (mst_req),
        .priority_i (mst_priority),
        .last_id_i  (last_id_q),
        .pick_o     (pick),
        .pick_id_o  (pick_id)
    );

    always_comb begin
        for (int i = 0; i < MASTERS; i++) begin
            trans[i] = mst_HTRANS[2*i +: 2];
        end
    end

    // A burst is recognised as continuing once the owner shows SEQ/BUSY; a lock
    // holds even through IDLE beats of the locked sequence.
    assign owner_trans = trans[grant_id_q];
    assign owner_hold  = mst_HMASTLOCK[grant_id_q] ||
                         (mst_req[grant_id_q] &&
                          ((owner_trans == HTRANS_SEQ) || (owner_trans == HTRANS_BUSY)));

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        grant_id_d   = grant_id_q;
        last_id_d    = last_id_q;
        data_id_d    = data_id_q;
        data_valid_d = data_valid_q;
        if (slv_HREADY) begin
            data_id_d    = grant_id_q;
            data_valid_d = owner_trans[1] && (state_q != ST_IDLE);
            if ((state_q != ST_IDLE) && owner_hold) begin
                state_d = ST_HOLD;
            end else if (|mst_req) begin
                state_d    = ST_OWNED;
                grant_d    = pick;
                grant_id_d = pick_id;
                last_id_d  = pick_id;
            end else begin
                state_d = ST_IDLE;
            end
        end
    end

    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            state_q      <= ST_IDLE;
            grant_q      <= {{(MASTERS-1){1'b0}}, 1'b1};
            grant_id_q   <= '0;
            last_id_q    <= IDW'(MASTERS-1);
            data_id_q    <= '0;
            data_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            grant_id_q   <= grant_id_d;
            last_id_q    <= last_id_d;
            data_id_q    <= data_id_d;
            data_valid_q <= data_valid_d;
        end
    end

    assign grant       = grant_q;
    assign grant_id    = grant_id_q;
    assign grant_valid = (state_q != ST_IDLE);
    assign data_id     = data_id_q;
    assign data_valid  = data_valid_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_peripheral_arbiter_ahb4.sv
// Bench for peripheral_arbiter_ahb4: directed scenarios with literal expectations,
// then random traffic, all checked every cycle against a behavioural model.
module tb_peripheral_arbiter_ahb4;
    import peripheral_ahb4_pkg::*;

    localparam int M  = 3;
    localparam int PB = 3;

    // ---------------- clock / reset / signals ----------------
    logic         HCLK = 1'b0;
    logic         HRESETn;
    logic [8:0]   mst_priority;
    logic [2:0]   mst_req;
    logic [5:0]   mst_HTRANS;
    logic [2:0]   mst_HMASTLOCK;
    logic         slv_HREADY;
    logic [2:0]   grant;
    logic [1:0]   grant_id;
    logic         grant_valid;
    logic [1:0]   data_id;
    logic         data_valid;
    arb_state_e   dbg_state;

    always #5 HCLK = ~HCLK;

    peripheral_arbiter_ahb4 #(.MASTERS(M), .PRIORITY_BITS(PB)) dut (
        .HCLK          (HCLK),
        .HRESETn       (HRESETn),
        .mst_priority  (mst_priority),
        .mst_req       (mst_req),
        .mst_HTRANS    (mst_HTRANS),
        .mst_HMASTLOCK (mst_HMASTLOCK),
        .slv_HREADY    (slv_HREADY),
        .grant         (grant),
        .grant_id      (grant_id),
        .grant_valid   (grant_valid),
        .data_id       (data_id),
        .data_valid    (data_valid),
        .dbg_state_o   (dbg_state)
    );

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Winner = highest priority among requesters; among equals, the first one
    // met when walking upward from last+1.
    function automatic int model_pick(input logic [2:0] req, input logic [8:0] pri, input int last);
        int best;
        int i;
        best = -1;
        for (int m = 0; m < M; m++) begin
            if (req[m] && int'(pri[m*PB +: PB]) > best) best = int'(pri[m*PB +: PB]);
        end
        for (int k = 1; k <= M; k++) begin
            i = (last + k) % M;
            if (req[i] && int'(pri[i*PB +: PB]) == best) return i;
        end
        return -1;
    endfunction

    logic [1:0]  m_gid;
    logic        m_gv;
    logic [1:0]  m_did;
    logic        m_dv;
    int          m_last;
    arb_state_e  m_state;
    logic [10:0] exp_q[$];
    logic [1:0]  m_ot;
    int          m_p;
    logic        m_hold;

    always @(posedge HCLK) begin
        if (!HRESETn) begin
            m_gid = 2'd0; m_gv = 1'b0; m_did = 2'd0; m_dv = 1'b0;
            m_last = M - 1; m_state = ST_IDLE;
        end else if (slv_HREADY) begin
            m_ot   = mst_HTRANS[m_gid*2 +: 2];
            m_did  = m_gid;
            m_dv   = m_gv && m_ot[1];
            m_hold = m_gv && (mst_HMASTLOCK[m_gid] ||
                     (mst_req[m_gid] && (m_ot == HTRANS_SEQ || m_ot == HTRANS_BUSY)));
            if (m_hold) begin
                m_state = ST_HOLD;
            end else begin
                m_p = model_pick(mst_req, mst_priority, m_last);
                if (m_p >= 0) begin
                    m_gid = 2'(m_p); m_last = m_p; m_state = ST_OWNED;
                end else begin
                    m_state = ST_IDLE;
                end
            end
            m_gv = (m_state != ST_IDLE);
        end
        exp_q.push_back({3'(1 << m_gid), m_gid, m_gv, m_did, m_dv, 2'(m_state)});
    end

    // ---------------- scoreboard compare ----------------
    logic [10:0] exp_v;
    always @(negedge HCLK) begin
        if (exp_q.size() > 0) begin
            exp_v = exp_q.pop_front();
            chk("sb_grant",       8'(grant),       8'(exp_v[10:8]));
            chk("sb_grant_id",    8'(grant_id),    8'(exp_v[7:6]));
            chk("sb_grant_valid", 8'(grant_valid), 8'(exp_v[5]));
            chk("sb_data_id",     8'(data_id),     8'(exp_v[4:3]));
            chk("sb_data_valid",  8'(data_valid),  8'(exp_v[2]));
            chk("sb_state",       8'(dbg_state),   8'(exp_v[1:0]));
        end
    end

    // ---------------- driver ----------------
    // Apply inputs, then return at the following falling edge so outputs
    // reflect the rising edge that sampled them.
    task automatic step(input logic rst_n, input logic [2:0] req, input logic [5:0] tr,
                        input logic [2:0] lock, input logic rdy);
        HRESETn       = rst_n;
        mst_req       = req;
        mst_HTRANS    = tr;
        mst_HMASTLOCK = lock;
        slv_HREADY    = rdy;
        @(negedge HCLK);
    endtask

    task automatic do_reset();
        step(1'b0, 3'b000, 6'b0, 3'b000, 1'b1);
        step(1'b0, 3'b000, 6'b0, 3'b000, 1'b1);
    endtask

    logic [2:0] r_req;
    logic [5:0] r_tr;
    logic [2:0] r_lock;

    initial begin
        HRESETn = 1'b0; mst_priority = '0; mst_req = '0;
        mst_HTRANS = '0; mst_HMASTLOCK = '0; slv_HREADY = 1'b1;

        // reset values
        do_reset();
        chk("rst_grant", 8'(grant), 8'h01);
        chk("rst_grant_id", 8'(grant_id), 8'h00);
        chk("rst_gvalid", 8'(grant_valid), 8'h00);
        chk("rst_dvalid", 8'(data_valid), 8'h00);
        chk("rst_state", 8'(dbg_state), 8'(ST_IDLE));

        // single request: grant next cycle, data phase one edge later
        step(1'b1, 3'b010, 6'b00_10_00, 3'b000, 1'b1);
        chk("single_grant", 8'(grant), 8'h02);
        chk("single_gid", 8'(grant_id), 8'h01);
        chk("single_gvalid", 8'(grant_valid), 8'h01);
        step(1'b1, 3'b010, 6'b00_10_00, 3'b000, 1'b1);
        chk("single_did", 8'(data_id), 8'h01);
        chk("single_dvalid", 8'(data_valid), 8'h01);
        step(1'b1, 3'b000, 6'b0, 3'b000, 1'b1);
        chk("park_gvalid", 8'(grant_valid), 8'h00);
        chk("park_grant", 8'(grant), 8'h02);

        // round-robin tie
        do_reset();
        mst_priority = 9'b011_011_011;
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 3'b111, 6'b10_10_10, 3'b000, 1'b1);
            chk("rr_gid", 8'(grant_id), 8'(i % 3));
        end

        // strict priority
        mst_priority = 9'b111_001_001;
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 3'b111, 6'b10_10_10, 3'b000, 1'b1);
            chk("prio_gid", 8'(grant_id), 8'h02);
        end

        // burst hold against a higher-priority requester
        do_reset();
        mst_priority = 9'b101_000_001;
        step(1'b1, 3'b001, 6'b00_00_10, 3'b000, 1'b1);
        chk("burst_grant", 8'(grant_id), 8'h00);
        step(1'b1, 3'b001, 6'b00_00_10, 3'b000, 1'b1);
        chk("burst_b1", 8'(grant_id), 8'h00);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 3'b101, 6'b10_00_11, 3'b000, 1'b1);
            chk("burst_seq", 8'(grant_id), 8'h00);
            chk("burst_hold", 8'(dbg_state), 8'(ST_HOLD));
        end
        chk("burst_did", 8'(data_id), 8'h00);
        chk("burst_dvalid", 8'(data_valid), 8'h01);
        step(1'b1, 3'b100, 6'b10_00_00, 3'b000, 1'b1);
        chk("burst_handoff", 8'(grant_id), 8'h02);

        // lock with stall
        do_reset();
        mst_priority = 9'b111_000_111;
        step(1'b1, 3'b010, 6'b00_10_00, 3'b010, 1'b1);
        chk("lock_grant", 8'(grant_id), 8'h01);
        for (int i = 1; i <= 6; i++) begin
            step(1'b1, 3'b111, 6'b10_10_10, 3'b010, (i == 2 || i == 3) ? 1'b0 : 1'b1);
            chk("lock_gid", 8'(grant_id), 8'h01);
            chk("lock_state", 8'(dbg_state), 8'(ST_HOLD));
        end
        step(1'b1, 3'b111, 6'b10_10_10, 3'b000, 1'b1);
        chk("unlock_gid", 8'(grant_id), 8'h02);

        // reset mid-burst
        step(1'b1, 3'b001, 6'b00_00_10, 3'b000, 1'b1);
        step(1'b1, 3'b001, 6'b00_00_11, 3'b000, 1'b1);
        step(1'b0, 3'b001, 6'b00_00_11, 3'b000, 1'b1);
        chk("mrst_grant", 8'(grant), 8'h01);
        chk("mrst_gvalid", 8'(grant_valid), 8'h00);
        chk("mrst_did", 8'(data_id), 8'h00);
        chk("mrst_dvalid", 8'(data_valid), 8'h00);
        chk("mrst_state", 8'(dbg_state), 8'(ST_IDLE));

        // random traffic, model-checked every cycle
        for (int c = 0; c < 500; c++) begin
            if ($urandom_range(0, 15) == 0) mst_priority = 9'($urandom_range(0, 511));
            r_req = 3'($urandom_range(0, 7));
            r_tr  = '0;
            for (int m = 0; m < M; m++) begin
                if (r_req[m]) r_tr[m*2 +: 2] = 2'($urandom_range(1, 3));
            end
            r_lock = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(0, 7)) : 3'b000;
            step(($urandom_range(0, 99) == 0) ? 1'b0 : 1'b1, r_req, r_tr, r_lock,
                 ($urandom_range(0, 3) == 0) ? 1'b0 : 1'b1);
        end

        @(negedge HCLK);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete, tests=%0d", tests);
        $fatal(1);
    end

endmodule
